// File: rtl/cr_kme_fifo_arb_if.sv
// Write-side bundle between requesters, the arbiter and the KME FIFO wrapper.
// master: requester/FIFO environment side; slave: the arbiter.
// Carries the per-requester valid/ready/data and the FIFO write port with its stall.
interface cr_kme_fifo_arb_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 83
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic [DW-1:0]       fifo_in;
  logic                fifo_in_valid;
  logic                fifo_in_stall;

  modport master (
    output req_valid, req_data, fifo_in_stall,
    input  req_ready, fifo_in, fifo_in_valid
  );

  modport slave (
    input  req_valid, req_data, fifo_in_stall,
    output req_ready, fifo_in, fifo_in_valid
  );
endinterface

// File: rtl/cr_kme_fifo_arb.sv
// Round-robin, packet-locking arbiter feeding one KME staging FIFO write port.
// Latency: grant one cycle after request in IDLE; data path req_data->fifo_in is combinational.
// Backpressure: fifo_in_stall gates ready and the write strobe in the same cycle, no skid.
module cr_kme_fifo_arb #(
  parameter int N_REQ     = 4,
  parameter int DW        = 83,
  parameter int EOP_BIT   = 82,
  parameter int MAX_BEATS = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arb_en,
  cr_kme_fifo_arb_if.slave           bus,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       pkt_too_long
);

  localparam int OW = $clog2(N_REQ);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [OW-1:0]  owner_q, owner_d;
  logic [OW-1:0]  last_q, last_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           too_long_q, too_long_d;
  logic [OW-1:0]  win;
  logic           win_vld;
  logic           xfer;
  logic [DW-1:0]  owner_dat;

  // Entry of the current owner; also what the FIFO sees on its data input.
  assign owner_dat   = bus.req_data[owner_q*DW +: DW];
  assign bus.fifo_in = owner_dat;

  // Round-robin search starting one past the last owner, wrapping around.
  always_comb begin
    win     = last_q;
    win_vld = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!win_vld && bus.req_valid[(int'(last_q) + i) % N_REQ]) begin
        win     = OW'((int'(last_q) + i) % N_REQ);
        win_vld = 1'b1;
      end
    end
  end

  // Next-state and handshake outputs: grant in IDLE, stream beats until EOP in LOCKED.
  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    last_d            = last_q;
    cnt_d             = cnt_q;
    too_long_d        = too_long_q;
    xfer              = 1'b0;
    bus.req_ready     = '0;
    bus.fifo_in_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_en && win_vld) begin
          state_d = LOCKED;
          owner_d = win;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        bus.req_ready[owner_q] = ~bus.fifo_in_stall;
        xfer                   = bus.req_valid[owner_q] & ~bus.fifo_in_stall;
        bus.fifo_in_valid      = xfer;
        if (xfer) begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          // Flag the beat that goes past MAX_BEATS; the packet itself is not cut.
          if (int'(cnt_q) == MAX_BEATS) too_long_d = 1'b1;
          if (owner_dat[EOP_BIT]) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register; last owner resets to N_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= OW'(N_REQ - 1);
      cnt_q      <= '0;
      too_long_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      too_long_q <= too_long_d;
    end
  end

  assign busy         = (state_q == LOCKED);
  assign owner        = owner_q;
  assign pkt_too_long = too_long_q;

endmodule

// File: doc/cr_kme_fifo_arb.md
# cr_kme_fifo_arb

Round-robin, packet-locking arbiter that shares one KME staging FIFO write port (83-bit entry, stall/valid interface) among up to N_REQ requesters. It sits directly in front of the KME FIFO wrapper and drives that wrapper's `fifo_in`/`fifo_in_valid`, honouring its `fifo_in_stall`. Once a requester wins, it owns the FIFO write port until it delivers an entry with the end-of-packet bit set, so multi-beat packets are never interleaved.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- DW, 83, entry width; matches the KME FIFO data width
- EOP_BIT, 82, bit index within an entry that marks end of packet
- MAX_BEATS, 64, packet length above which `pkt_too_long` is flagged

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  reset, synchronous, active-high
- arb_en  in  1  1 = new grants allowed; 0 = finish the current packet, then hold in IDLE
- req_valid  in  N_REQ  per-requester entry valid
- req_data  in  N_REQ*DW  per-requester entry; requester i occupies bits [i*DW +: DW]
- req_ready  out  N_REQ  per-requester accept; a beat transfers when valid & ready
- fifo_in  out  DW  entry to the FIFO wrapper
- fifo_in_valid  out  1  write strobe to the FIFO wrapper
- fifo_in_stall  in  1  FIFO wrapper full (free_slots == 0)
- busy  out  1  1 while in LOCKED
- owner  out  clog2(N_REQ)  index of the current or last owner
- pkt_too_long  out  1  sticky error flag

## Operation
- FSM states: IDLE, LOCKED.
- IDLE:
  - If arb_en = 1 and any req_valid is set, pick the winner by round-robin.
  - Search starts at (last_owner + 1) mod N_REQ, wrapping around.
  - Register the winner in `owner`, clear the beat counter, and go to LOCKED.
  - No beat transfers in IDLE; every req_ready is 0.
- LOCKED:
  - req_ready[owner] = ~fifo_in_stall. All other req_ready are 0.
  - fifo_in = req_data[owner].
  - fifo_in_valid = req_valid[owner] & ~fifo_in_stall. Never assert it while the FIFO is stalled; the wrapper overflows otherwise.
  - On each transfer the beat counter increments. The counter is 8 bits and saturates at 255.
  - If a transfer occurs while the count already equals MAX_BEATS, set pkt_too_long. It stays set until rst. The packet still continues.
  - A transfer with req_data[owner][EOP_BIT] = 1 moves the FSM to IDLE next cycle and makes last_owner = owner.
- The owner dropping req_valid mid-packet keeps the lock; the arbiter waits indefinitely.
- arb_en = 0 while in LOCKED has no effect until EOP.
- The datapath is combinational from req_data to fifo_in; only the control is registered.

## Timing
- Reset values: state IDLE, owner 0, last_owner N_REQ-1 (so requester 0 has first priority), beat counter 0, pkt_too_long 0, busy 0. Consequently req_ready is 0 and fifo_in_valid is 0 out of reset.
- Arbitration latency: req_valid seen in IDLE in cycle T → owner and busy valid in T+1 → first transfer possible in T+1.
- After an EOP transfer in cycle T: IDLE in T+1, next grant in T+1, next transfer in T+2. This gives one bubble cycle per packet.
- Throughput: one beat per cycle while in LOCKED, valid = 1 and stall = 0.
- fifo_in_stall rising in cycle T gates the transfer in that same cycle. There is no skid.
- rst asserted mid-packet: all state returns to reset values on the next edge, and the partial packet is abandoned. The FIFO wrapper is reset separately by its own reset.
- Simultaneous EOP transfer and new requests: the new requests are considered only in the following IDLE cycle.

## Test plan
- Single requester:
  - Stimulus: requester 2 sends a 3-beat packet (EOP on beat 3), no stall.
  - Response: busy rises 1 cycle after req_valid; 3 consecutive fifo_in_valid pulses carrying the data unchanged; IDLE after the third beat.
- Round-robin:
  - Stimulus: all 4 requesters continuously send 1-beat packets, starting after reset.
  - Response: grant order 0,1,2,3,0,…; one transfer every 2 cycles.
- Lock under contention:
  - Stimulus: requester 1 sends a 4-beat packet while requester 0 holds req_valid.
  - Response: no requester-0 beat appears between requester 1's beats; requester 0 is granted after requester 1's EOP.
- Stall:
  - Stimulus: fifo_in_stall held high for 5 cycles mid-packet.
  - Response: fifo_in_valid and req_ready[owner] are 0 for exactly those 5 cycles; no beat is lost or duplicated.
- Error and enable:
  - Stimulus: a 66-beat packet with MAX_BEATS = 64, then arb_en = 0.
  - Response: pkt_too_long rises on beat 65 and stays high; after EOP no new grant occurs while requests are pending.
- Reset mid-packet:
  - Stimulus: rst pulsed on beat 2 of a 5-beat packet.
  - Response: busy = 0, owner = 0, req_ready = 0 on the next cycle; the next arbitration favours requester 0.
